// File: rtl/shift_chain_reader.sv
// Frame reader for a daisy-chain of 74HC165-style PISO shift registers (shld/serclk/serin).
// Build option SHIFT_CHAIN_CONTINUOUS_EN: frames run back-to-back from reset release, start ignored.
`timescale 1ns/1ps
module shift_chain_reader #(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 2,
  parameter int DIV    = 1,
  parameter int CW     = $clog2(WIDTH*CHAINS+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      serin,
  output logic                      shld,
  output logic                      serclk,
  output logic                      busy,
  output logic                      done,
  output logic [CW-1:0]             count,
  output logic [WIDTH*CHAINS-1:0]   data_out
);

  localparam int TOTAL = WIDTH * CHAINS;
  localparam int DW    = $clog2(2 * DIV);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [DW-1:0] LOAD_LAST  = DW'(2 * DIV - 1);
  localparam logic [DW-1:0] PHASE_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(TOTAL - 1);

  logic [2:0]       state;
  logic [DW-1:0]    div_cnt;
  logic [TOTAL-1:0] sreg;
  logic [TOTAL-1:0] sreg_nxt;
  logic             go;

`ifdef SHIFT_CHAIN_CONTINUOUS_EN
  assign go = start | 1'b1;
`else
  assign go = start;
`endif

  // First bit sampled ends up in the MSB once all TOTAL bits are in.
  assign sreg_nxt = {sreg[TOTAL-2:0], serin};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shld     <= 1'b1;
      serclk   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      data_out <= '0;
      sreg     <= '0;
      div_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          serclk  <= 1'b0;
          div_cnt <= '0;
          if (go) begin
            state <= S_LOAD;
            shld  <= 1'b0;
            busy  <= 1'b1;
            count <= '0;
          end else begin
            state <= S_IDLE;
            shld  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (div_cnt == LOAD_LAST) begin
            state   <= S_LO;
            shld    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_LO: begin
          if (div_cnt == PHASE_LAST) begin
            div_cnt <= '0;
            sreg    <= sreg_nxt;
            count   <= count + CW'(1);
            if (count == LAST_BIT) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              data_out <= sreg_nxt;
            end else begin
              state  <= S_HI;
              serclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_HI: begin
          if (div_cnt == PHASE_LAST) begin
            state   <= S_LO;
            serclk  <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          shld   <= 1'b1;
          serclk <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_reader.sv
// Directed bench for shift_chain_reader: default config (u0) and WIDTH=8/CHAINS=3/DIV=3 (u1).
`timescale 1ns/1ps
module tb_shift_chain_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic serin0, serin1;
  logic shld0, serclk0, busy0, done0;
  logic shld1, serclk1, busy1, done1;
  logic [4:0]  count0, count1;
  logic [15:0] data0;
  logic [23:0] data1;
  logic [15:0] pdata0 = 16'h0000;
  logic [23:0] pdata1 = 24'h000000;
  logic [15:0] chain0 = 16'h0000;
  logic [23:0] chain1 = 24'h000000;
  logic sc0_q = 1'b0, sc1_q = 1'b0;
  int rises0 = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_chain_reader u0 (
    .clk(clk), .reset(reset), .start(start0), .serin(serin0),
    .shld(shld0), .serclk(serclk0), .busy(busy0), .done(done0),
    .count(count0), .data_out(data0)
  );

  shift_chain_reader #(.WIDTH(8), .CHAINS(3), .DIV(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .serin(serin1),
    .shld(shld1), .serclk(serclk1), .busy(busy1), .done(done1),
    .count(count1), .data_out(data1)
  );

  // Chain models: parallel load while shld=0, shift one bit per serclk rise, QH = MSB.
  assign serin0 = chain0[15];
  assign serin1 = chain1[23];

  always @(posedge clk) begin
    sc0_q <= serclk0;
    if (!shld0) chain0 <= pdata0;
    else if (serclk0 && !sc0_q) begin
      chain0 <= {chain0[14:0], 1'b0};
      rises0 <= rises0 + 1;
    end
  end

  always @(posedge clk) begin
    sc1_q <= serclk1;
    if (!shld1) chain1 <= pdata1;
    else if (serclk1 && !sc1_q) chain1 <= {chain1[22:0], 1'b0};
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (shld0 !== 1'b1) begin n_fail++; $display("FAIL reset_shld got %b want 1", shld0); end
    n_checks++; if (serclk0 !== 1'b0) begin n_fail++; $display("FAIL reset_serclk got %b want 0", serclk0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done0); end
    n_checks++; if (count0 !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count0); end
    n_checks++; if (data0 !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", data0); end
    n_checks++; if (data1 !== 24'h000000) begin n_fail++; $display("FAIL reset_data1 got %h want 000000", data1); end
  endtask

`ifndef SHIFT_CHAIN_CONTINUOUS_EN
  task automatic test_single_frame;
    int done_edge, done_cnt, shld_lo, r0;
    logic busy_load;
    pdata0 = 16'hA5C3;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    r0 = rises0; done_edge = -1; done_cnt = 0; shld_lo = 0; busy_load = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      @(negedge clk);
      if (e == 0) busy_load = busy0;
      if (!shld0) shld_lo++;
      if (done0) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL t1_busy_in_done got %b want 0", busy0); end
      end
    end
    n_checks++; if (busy_load !== 1'b1) begin n_fail++; $display("FAIL t1_busy_load got %b want 1", busy_load); end
    n_checks++; if (shld_lo != 2) begin n_fail++; $display("FAIL t1_load_cycles got %0d want 2", shld_lo); end
    n_checks++; if (rises0 - r0 != 15) begin n_fail++; $display("FAIL t1_serclk_rises got %0d want 15", rises0 - r0); end
    n_checks++; if (done_edge != 33) begin n_fail++; $display("FAIL t1_done_edge got %0d want 33", done_edge); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t1_done_count got %0d want 1", done_cnt); end
    n_checks++; if (data0 !== 16'hA5C3) begin n_fail++; $display("FAIL t1_data got %h want a5c3", data0); end
    n_checks++; if (count0 !== 5'd16) begin n_fail++; $display("FAIL t1_count got %0d want 16", count0); end
  endtask

  task automatic test_div3;
    int done_edge, shld_lo, hi_cyc;
    pdata1 = 24'h123456;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    done_edge = -1; shld_lo = 0; hi_cyc = 0;
    for (int e = 0; e <= 200; e++) begin
      @(negedge clk);
      if (!shld1) shld_lo++;
      if (serclk1) hi_cyc++;
      if (done1 && done_edge < 0) done_edge = e;
    end
    n_checks++; if (shld_lo != 6) begin n_fail++; $display("FAIL t2_load_cycles got %0d want 6", shld_lo); end
    n_checks++; if (hi_cyc != 69) begin n_fail++; $display("FAIL t2_serclk_high_cycles got %0d want 69", hi_cyc); end
    n_checks++; if (done_edge != 147) begin n_fail++; $display("FAIL t2_done_edge got %0d want 147", done_edge); end
    n_checks++; if (data1 !== 24'h123456) begin n_fail++; $display("FAIL t2_data got %h want 123456", data1); end
    n_checks++; if (count1 !== 5'd24) begin n_fail++; $display("FAIL t2_count got %0d want 24", count1); end
  endtask

  task automatic test_back_to_back;
    int waited, gap;
    bit found;
    pdata0 = 16'h00FF;
    @(negedge clk); start0 = 1'b1;
    found = 1'b0;
    for (waited = 0; waited < 60 && !found; waited++) begin
      @(negedge clk);
      if (done0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL t3_first_done got timeout want done within 60"); end
    n_checks++; if (data0 !== 16'h00FF) begin n_fail++; $display("FAIL t3_data_a got %h want 00ff", data0); end
    pdata0 = 16'hFF00;
    @(negedge clk);
    n_checks++; if (shld0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL t3_load_after_done got shld=%b busy=%b want 0/1", shld0, busy0); end
    gap = 1; found = 1'b0;
    while (gap < 80 && !found) begin
      @(negedge clk);
      gap++;
      if (done0) found = 1'b1;
    end
    start0 = 1'b0;
    n_checks++; if (gap != 34) begin n_fail++; $display("FAIL t3_done_period got %0d want 34", gap); end
    n_checks++; if (data0 !== 16'hFF00) begin n_fail++; $display("FAIL t3_data_b got %h want ff00", data0); end
    @(negedge clk);
    n_checks++; if (busy0 !== 1'b0 || shld0 !== 1'b1) begin n_fail++; $display("FAIL t3_idle_after got busy=%b shld=%b want 0/1", busy0, shld0); end
  endtask

  task automatic test_reset_midframe;
    int done_edge;
    bit found, saw_done;
    pdata0 = 16'hA5C3;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (count0 == 5'd7) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL t4_reach_bit7 got timeout want count=7"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (shld0 !== 1'b1 || serclk0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL t4_ctrl got shld=%b serclk=%b busy=%b want 1/0/0", shld0, serclk0, busy0); end
    n_checks++; if (count0 !== 5'd0) begin n_fail++; $display("FAIL t4_count got %0d want 0", count0); end
    n_checks++; if (data0 !== 16'h0000) begin n_fail++; $display("FAIL t4_data got %h want 0000", data0); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL t4_no_done got done=1 want 0"); end
    pdata0 = 16'h3C5A;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    done_edge = -1;
    for (int e = 0; e <= 45; e++) begin
      @(negedge clk);
      if (done0 && done_edge < 0) done_edge = e;
    end
    n_checks++; if (done_edge != 33) begin n_fail++; $display("FAIL t4_fresh_done_edge got %0d want 33", done_edge); end
    n_checks++; if (data0 !== 16'h3C5A) begin n_fail++; $display("FAIL t4_fresh_data got %h want 3c5a", data0); end
  endtask

  task automatic test_start_ignored;
    int done_edge, done_cnt;
    pdata0 = 16'h5AA5;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    done_edge = -1; done_cnt = 0;
    for (int e = 0; e <= 80; e++) begin
      @(negedge clk);
      if (done0) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      start0 = (e >= 1 && e <= 30) ? e[0] : 1'b0;
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t5_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_edge != 33) begin n_fail++; $display("FAIL t5_done_edge got %0d want 33", done_edge); end
    n_checks++; if (data0 !== 16'h5AA5) begin n_fail++; $display("FAIL t5_data got %h want 5aa5", data0); end
  endtask
`else
  task automatic test_continuous;
    int first0, second0, first1;
    logic busy_after;
    logic [15:0] d0_first;
    pdata0 = 16'hC33C;
    pdata1 = 24'hABCDEF;
    @(negedge clk); reset = 1'b0;
    first0 = -1; second0 = -1; first1 = -1; busy_after = 1'b0; d0_first = 16'h0000;
    for (int e = 0; e <= 160; e++) begin
      @(negedge clk);
      if (first0 >= 0 && e == first0 + 1) busy_after = busy0;
      if (done0) begin
        if (first0 < 0) begin first0 = e; d0_first = data0; end
        else if (second0 < 0) second0 = e;
      end
      if (done1 && first1 < 0) first1 = e;
    end
    n_checks++; if (first0 != 33) begin n_fail++; $display("FAIL t6_first_done got %0d want 33", first0); end
    n_checks++; if (second0 - first0 != 34) begin n_fail++; $display("FAIL t6_done_period got %0d want 34", second0 - first0); end
    n_checks++; if (busy_after !== 1'b1) begin n_fail++; $display("FAIL t6_load_after_done got %b want 1", busy_after); end
    n_checks++; if (d0_first !== 16'hC33C) begin n_fail++; $display("FAIL t6_data got %h want c33c", d0_first); end
    n_checks++; if (first1 != 147) begin n_fail++; $display("FAIL t6_div3_done got %0d want 147", first1); end
    n_checks++; if (data1 !== 24'hABCDEF) begin n_fail++; $display("FAIL t6_div3_data got %h want abcdef", data1); end
  endtask
`endif

  initial begin
    test_reset;
`ifndef SHIFT_CHAIN_CONTINUOUS_EN
    @(negedge clk); reset = 1'b0;
    test_single_frame;
    test_div3;
    test_back_to_back;
    test_reset_midframe;
    test_start_ignored;
`else
    test_continuous;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
